// File: rtl/src_memory_if.sv
// src_memory CPU-side request/handshake bundle.
// master drives address/read/enable; slave returns mem_ready.
interface src_memory_if;
   logic [15:0] address;
   logic        read;
   logic        enable;
   logic        mem_ready;

   modport master (
      output address,
      output read,
      output enable,
      input  mem_ready
   );

   modport slave (
      input  address,
      input  read,
      input  enable,
      output mem_ready
   );
endinterface

// File: rtl/src_memory.sv
// src_memory: word-addressed 32-bit RAM behind the SRC memory controller.
// Ports: clk, rst_n (async low), cpu (address/read/enable/mem_ready),
// mem_bus (shared tri-state data), addr_err (sticky), loader
// load_en/load_addr/load_data with one-cycle load_ack pulse.
module src_memory #(
   parameter int DEPTH       = 4096,
   parameter int WAIT_STATES = 0
) (
   input  logic        clk,
   input  logic        rst_n,
   src_memory_if.slave cpu,
   inout  wire  [31:0] mem_bus,
   output logic        addr_err,
   input  logic        load_en,
   input  logic [15:0] load_addr,
   input  logic [31:0] load_data,
   output logic        load_ack
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [16:0] LIMIT = 17'(DEPTH);
   localparam bit NO_WAIT = (WAIT_STATES == 0);
   localparam logic [3:0] WS_LOAD =
      4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] WAIT  = 2'd1;
   localparam logic [1:0] DRIVE = 2'd2;
   localparam logic [1:0] DONE  = 2'd3;

   logic [31:0] mem [DEPTH];

   logic [1:0]  state;
   logic [15:0] addr_lat;
   logic        read_lat;
   logic [3:0]  cnt;
   logic [31:0] data_q;

   logic        start;
   logic        fin;
   logic [15:0] fin_addr;
   logic        fin_read;
   logic        fin_ok;
   logic        load_go;
   logic        load_ok;
   logic        we;
   logic [AW-1:0] waddr;
   logic [31:0] wdata;
   logic [31:0] rdata;

   // With no wait states the transaction completes on its start edge,
   // so the completing edge must use the live request, not the latch.
   always_comb begin
      start    = (state == IDLE) && cpu.enable;
      fin_addr = (state == IDLE) ? cpu.address : addr_lat;
      fin_read = (state == IDLE) ? cpu.read : read_lat;
      fin      = (start && NO_WAIT) ||
                 ((state == WAIT) && cpu.enable && (cnt == 4'd0));
      fin_ok   = {1'b0, fin_addr} < LIMIT;
      load_go  = (state == IDLE) && !cpu.enable && load_en;
      load_ok  = {1'b0, load_addr} < LIMIT;
      rdata    = fin_ok ? mem[fin_addr[AW-1:0]] : 32'h0000_0000;
   end

   always_comb begin
      we    = 1'b0;
      waddr = fin_addr[AW-1:0];
      wdata = mem_bus;
      if (fin && !fin_read && fin_ok) begin
         we = 1'b1;
      end else if (load_go && load_ok) begin
         we    = 1'b1;
         waddr = load_addr[AW-1:0];
         wdata = load_data;
      end
   end

   // Contents survive reset; an edge seen under reset commits nothing.
   always_ff @(posedge clk) begin
      if (rst_n && we) begin
         mem[waddr] <= wdata;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         addr_lat      <= 16'h0000;
         read_lat      <= 1'b0;
         cnt           <= 4'd0;
         data_q        <= 32'h0000_0000;
         cpu.mem_ready <= 1'b0;
         addr_err      <= 1'b0;
         load_ack      <= 1'b0;
      end else begin
         load_ack <= load_go;
         if ((load_go && !load_ok) || (fin && !fin_ok)) begin
            addr_err <= 1'b1;
         end
         case (state)
            IDLE: begin
               if (start) begin
                  addr_lat <= cpu.address;
                  read_lat <= cpu.read;
                  if (!NO_WAIT) begin
                     cnt   <= WS_LOAD;
                     state <= WAIT;
                  end
               end
            end
            WAIT: begin
               if (!cpu.enable) begin
                  state <= IDLE;
               end else if (cnt != 4'd0) begin
                  cnt <= cnt - 4'd1;
               end
            end
            DRIVE, DONE: begin
               if (!cpu.enable) begin
                  state         <= IDLE;
                  cpu.mem_ready <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
         // Completion overrides the per-state moves above.
         if (fin) begin
            state         <= fin_read ? DRIVE : DONE;
            cpu.mem_ready <= 1'b1;
            if (fin_read) begin
               data_q <= rdata;
            end
         end
      end
   end

   // Gated by live enable so the bus frees in the cycle enable drops.
   assign mem_bus = ((state == DRIVE) && cpu.enable && read_lat)
                    ? data_q : 32'hzzzz_zzzz;

endmodule

// File: doc/src_memory.md
# src_memory

Word-addressed 32-bit synchronous RAM that sits directly downstream of the SRC CPU's memory controller on the external `mem_bus`/`address`/`read`/`enable` interface. It serves CPU read and write transactions with a configurable number of wait states, drives the shared tri-state `mem_bus` only while returning read data, and signals completion with `mem_ready`. A side-band loader port preloads program and data images when the bus is idle.

## Interface
- `DEPTH`, 4096: number of implemented 32-bit words; valid addresses are 0..DEPTH-1 (DEPTH ≤ 65536).
- `WAIT_STATES`, 0: extra cycles inserted before a transaction completes (0..15).
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `mem_bus`  inout  32  shared data bus; driven by this block only during read data return, otherwise `z`.
- `address`  in  16  word address from the CPU memory controller.
- `read`  in  1  1 = read, 0 = write; qualified by `enable`.
- `enable`  in  1  transaction request; held high by the CPU until it has consumed the result.
- `mem_ready`  out  1  transaction complete (read data valid / write committed).
- `addr_err`  out  1  sticky: an access to an address ≥ DEPTH occurred.
- `load_en`  in  1  loader write request.
- `load_addr`  in  16  loader word address.
- `load_data`  in  32  loader write data.
- `load_ack`  out  1  one-cycle pulse: the loader write was accepted.

## Operation
- States: IDLE, WAIT, DRIVE (read complete), DONE (write complete).
- IDLE: on a rising edge with `enable`=1, latch `address` and `read` into internal registers and start the transaction. All later `address`/`read` changes are ignored until the state returns to IDLE.
  - If WAIT_STATES=0, go straight to DRIVE (read) or DONE (write).
  - Otherwise load the wait counter with WAIT_STATES-1 and go to WAIT.
- WAIT: decrement the counter each cycle. When the counter is 0, go to DRIVE or DONE on the next edge. If `enable` is sampled 0, abort: go to IDLE with no drive and no write.
- Reads: the data register is loaded with `mem[addr_lat]` on the edge entering DRIVE. Out-of-range addresses load 32'h0000_0000.
- Writes: `mem[addr_lat]` ← `mem_bus` on the edge entering DONE. Out-of-range writes are discarded.
- Out-of-range access (latched address ≥ DEPTH) sets `addr_err` on the edge entering DRIVE or DONE.
- DRIVE and DONE: `mem_ready`=1. Leave for IDLE on the first edge with `enable`=0.
- Bus drive: `mem_bus` = data register iff state==DRIVE && `enable` && `read_lat`, else `z` (combinational gate). Dropping `enable` releases the bus in the same cycle.
- Loader: accepted only in IDLE with `enable`=0 and `load_en`=1. An accepted write does `mem[load_addr]` ← `load_data` and pulses `load_ack` on the next cycle.
  - If `enable` and `load_en` are both 1 in IDLE, the CPU wins and the load is not acked. The loader must hold `load_en` until it sees `load_ack`.
  - Loads to addresses ≥ DEPTH are acked and discarded, and set `addr_err`.
- Reset (asserted any time, including mid-transaction):
  - State → IDLE; `mem_ready`=0, `addr_err`=0, `load_ack`=0; bus released immediately; wait counter cleared.
  - Memory contents are not cleared; a write is never partially committed.

## Timing
- Read latency from the edge sampling `enable`=1 in IDLE to `mem_ready`=1 and data on the bus: WAIT_STATES+1 edges.
- For WAIT_STATES=0 this matches a CPU that asserts `enable` in cycle N and captures `mem_bus` at the end of cycle N+1.
- Write commit: WAIT_STATES+1 edges after start. `mem_bus` must hold valid write data on that edge.
- `mem_ready` is registered and deasserts on the edge after `enable` is sampled low.
- The earliest back-to-back transaction starts 1 edge after returning to IDLE, so there is 1 idle cycle minimum.
- `load_ack` has 1-cycle latency and is never high for two consecutive cycles for the same request.
- Reads of a word written in the immediately preceding transaction return the new value.

## Test plan
- Preload: load words 0..3 = 32'h11111111..32'h44444444 via the loader → 4 `load_ack` pulses; no bus activity.
- WAIT_STATES=0, read addr 2 → `mem_ready` and `mem_bus`=32'h33333333 exactly 1 edge after `enable`; bus returns to `z` in the same cycle `enable` drops.
- WAIT_STATES=3, write 32'hCAFEF00D to addr 7, then read addr 7 → `mem_ready` 4 edges after each start; read returns 32'hCAFEF00D.
- Abort: WAIT_STATES=3, drop `enable` after 1 cycle of a write to addr 1 → state IDLE, `mem[1]` still 32'h22222222, `mem_ready` never asserted.
- Out of range (DEPTH=4096): read addr 16'h2000 → data 0 and `addr_err`=1, remaining 1 until reset; a write to addr 16'hFFFF changes no memory word.
- Contention and reset: `enable` and `load_en` asserted together in IDLE → CPU read served, `load_ack` only after `enable` drops. Assert `rst_n`=0 while in DRIVE → bus `z` and all outputs 0 immediately; preloaded contents intact.
